// File: rtl/mux_pipe_pkg.sv
// Shared state encodings and slice helper for the mux pipeline stage.
package mux_pipe_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_TWO   = ST_TWO
    } state_t;

    function automatic int slice_lo(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/mux_nto1.sv
// Combinational N-to-1 selector; latency 0, no backpressure.
// Any select code outside 0..NUM_IN-1 falls back to input 0.
module mux_nto1
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic [SEL_W-1:0]        i_sel,
    input  logic [NUM_IN*WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0]        o_dat
);

    always_comb begin
        o_dat = i_dat[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_dat = i_dat[slice_lo(k, WIDTH) +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_pipe_stage.sv
// N-to-1 selector with a registered output and a 2-entry skid buffer; latency 1 cycle.
// Valid/ready backpressure: in_ready_o drops only when both entries are full. Optional MUX_SEL_CHECK_EN adds sel_err_o.
module mux_pipe_stage
    import mux_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [SEL_W-1:0]        select_i,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
`ifdef MUX_SEL_CHECK_EN
    output logic                    sel_err_o,
`endif
    output logic [WIDTH-1:0]        data_o
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_in_rdy;
    logic [WIDTH-1:0]   r_out_dat;
    logic [WIDTH-1:0]   r_skid_dat;
    logic [WIDTH-1:0]   w_sel_dat;
    logic               w_push;
    logic               w_pop;
    logic               w_load_out;
    logic               w_load_skid;
    logic               w_skid_to_out;

    mux_nto1 #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .i_sel  (select_i),
        .i_dat  (data_i),
        .o_dat  (w_sel_dat)
    );

    assign w_push      = in_valid_i & r_in_rdy;
    assign w_pop       = out_valid_o & out_ready_i;
    assign in_ready_o  = r_in_rdy;
    assign out_valid_o = (r_state != S_EMPTY);
    assign data_o      = r_out_dat;

    always_comb begin
        w_state_nxt   = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        if (flush_i) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = S_ONE;
                        w_load_out  = 1'b1;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        w_load_out = 1'b1;
                    end else if (w_push) begin
                        w_state_nxt = S_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_pop) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        w_state_nxt   = S_ONE;
                        w_skid_to_out = 1'b1;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_EMPTY;
            r_in_rdy   <= 1'b1;
            r_out_dat  <= '0;
            r_skid_dat <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_in_rdy <= (w_state_nxt != S_TWO);
            if (w_load_out) begin
                r_out_dat <= w_sel_dat;
            end else if (w_skid_to_out) begin
                r_out_dat <= r_skid_dat;
            end
            if (w_load_skid) begin
                r_skid_dat <= w_sel_dat;
            end
        end
    end

`ifdef MUX_SEL_CHECK_EN
    logic r_sel_err;
    logic w_sel_oor;

    // Sticky until reset; flush deliberately leaves it set.
    assign w_sel_oor = (32'(select_i) >= 32'(NUM_IN));
    assign sel_err_o = r_sel_err;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_sel_err <= 1'b0;
        end else if (w_push && w_sel_oor) begin
            r_sel_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Directed scoreboard bench for mux_pipe_stage (4 inputs, 3-bit select so out-of-range codes exist).
module tb_mux_pipe_stage;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 4;
    localparam int SEL_W  = 3;

    logic                    clk;
    logic                    rst_n;
    logic                    flush;
    logic                    in_vld;
    logic                    in_rdy;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        din [NUM_IN];
    logic [NUM_IN*WIDTH-1:0] data_flat;
    logic                    out_vld;
    logic                    out_rdy;
    logic [WIDTH-1:0]        data_o;
    logic                    sel_err;

    int                      vectors = 0;
    int                      errs    = 0;
    logic [WIDTH-1:0]        q [$];
    logic                    err_exp = 1'b0;
    logic [WIDTH-1:0]        word_a;

    assign data_flat = {din[3], din[2], din[1], din[0]};

    mux_pipe_stage #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .flush_i     (flush),
        .in_valid_i  (in_vld),
        .in_ready_o  (in_rdy),
        .select_i    (sel),
        .data_i      (data_flat),
        .out_valid_o (out_vld),
        .out_ready_i (out_rdy),
`ifdef MUX_SEL_CHECK_EN
        .sel_err_o   (sel_err),
`endif
        .data_o      (data_o)
    );

`ifndef MUX_SEL_CHECK_EN
    assign sel_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] exp_word(input logic [SEL_W-1:0] s);
        if (int'(s) >= NUM_IN) return din[0];
        return din[s];
    endfunction

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: check occupancy-derived flags at the negedge, update the model, then step past the edge.
    task automatic tick();
        logic m_push;
        logic m_pop;
        @(negedge clk);
        chk("out_valid", {31'd0, out_vld}, {31'd0, q.size() != 0});
        chk("in_ready",  {31'd0, in_rdy},  {31'd0, q.size() < 2});
`ifdef MUX_SEL_CHECK_EN
        chk("sel_err",   {31'd0, sel_err}, {31'd0, err_exp});
`endif
        m_push = in_vld && (q.size() < 2);
        m_pop  = (q.size() != 0) && out_rdy;
        if (m_push && int'(sel) >= NUM_IN) err_exp = 1'b1;
        if (flush) begin
            q.delete();
        end else begin
            if (m_pop) chk("data", data_o, q.pop_front());
            if (m_push) q.push_back(exp_word(sel));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] w);
        sel    = s;
        din[int'(s) >= NUM_IN ? 0 : int'(s)] = w;
        in_vld = 1'b1;
        tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        sel     = '0;
        for (int i = 0; i < NUM_IN; i++) din[i] = 32'h1111_1111 * (i + 1);

        #12;
        chk("rst_out_valid", {31'd0, out_vld}, 32'd0);
        chk("rst_data",      data_o,           32'd0);
        chk("rst_in_ready",  {31'd0, in_rdy},  32'd1);
        chk("rst_sel_err",   {31'd0, sel_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single word, one-cycle latency, then empty.
        out_rdy = 1'b1;
        push_word(3'd2, 32'hDEAD_BEEF);
        in_vld = 1'b0;
        tick();
        tick();

        // Full-rate stream with select cycling.
        for (int i = 0; i < 8; i++) push_word(3'(i % 4), $urandom);
        in_vld = 1'b0;
        tick();
        tick();

        // Out-of-range select falls back to input 0.
        din[1] = 32'hBAD0_0001;
        push_word(3'd5, 32'hC0DE_0000);
        in_vld = 1'b0;
        tick();
        tick();

        // Stall: fill both entries, hold, then drain in order.
        out_rdy = 1'b0;
        word_a  = 32'hAAAA_0001;
        push_word(3'd1, word_a);
        push_word(3'd3, 32'hBBBB_0002);
        in_vld = 1'b0;
        tick();
        chk("hold_data", data_o, word_a);
        out_rdy = 1'b1;
        tick();
        tick();
        tick();

        // Flush from TWO with a pending word.
        out_rdy = 1'b0;
        push_word(3'd0, 32'h0F0F_0001);
        push_word(3'd1, 32'h0F0F_0002);
        sel    = 3'd2;
        din[2] = 32'h0F0F_0003;
        in_vld = 1'b1;
        flush  = 1'b1;
        tick();
        flush  = 1'b0;
        in_vld = 1'b0;
        tick();

        // Flush from ONE with an accepted push in the same cycle.
        push_word(3'd3, 32'h5555_0001);
        flush   = 1'b1;
        out_rdy = 1'b1;
        push_word(3'd2, 32'h5555_0002);
        flush = 1'b0;
        push_word(3'd1, 32'h5555_0003);
        in_vld = 1'b0;
        tick();
        tick();

        // Asynchronous reset while full, between edges.
        out_rdy = 1'b0;
        push_word(3'd0, 32'h7777_0001);
        push_word(3'd2, 32'h7777_0002);
        in_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_vld}, 32'd0);
        chk("arst_data",      data_o,           32'd0);
        chk("arst_in_ready",  {31'd0, in_rdy},  32'd1);
        chk("arst_sel_err",   {31'd0, sel_err}, 32'd0);
        q.delete();
        err_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tick();

        // Traffic after reset recovers normally.
        out_rdy = 1'b1;
        push_word(3'd3, 32'h9999_0001);
        in_vld = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
